lsu_stage: RTL

- Memory-access stage of the NPC pipeline; sits directly upstream of the writeback stage.
- Accepts one instruction at a time from execute over a valid/ready handshake.
- Loads and stores issue a single request on a req/rsp data-memory port; loads are aligned and sign/zero extended.
- Registers alu_result, dmem_rdata, reg_wdata_sel, csr_rdata and the reg-write enable toward writeback.

---
 rtl/lsu_pkg.sv | 30 +++
 rtl/lsu_align.sv | 52 +++++
 rtl/lsu_stage.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store stage: FSM encoding, funct3 codes,
// datapath width and the alignment predicate used by the misalign check.
package lsu_pkg;

    localparam int DATA_BUS = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RSP  = 2'd2
    } lsu_state_e;

    localparam logic [2:0] LSU_B  = 3'b000;
    localparam logic [2:0] LSU_H  = 3'b001;
    localparam logic [2:0] LSU_W  = 3'b010;
    localparam logic [2:0] LSU_BU = 3'b100;
    localparam logic [2:0] LSU_HU = 3'b101;

    // Access size lives in funct3[1:0]; bytes can never be misaligned.
    function automatic logic is_misaligned(input logic [2:0] op, input logic [1:0] addr_lo);
        logic mis;
        case (op[1:0])
            2'b01:   mis = addr_lo[0];
            2'b10:   mis = (addr_lo != 2'b00);
            default: mis = 1'b0;
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane steering: store strobes/data from op/addr/rs2 and the
// sign- or zero-extended load value from op/addr/read word.
module lsu_align
    import lsu_pkg::*;
#(
    parameter int DATA_W = DATA_BUS
) (
    input  logic [2:0]        op_i,
    input  logic [1:0]        addr_lo_i,
    input  logic [DATA_W-1:0] rs2_i,
    input  logic [DATA_W-1:0] rdata_i,
    output logic [3:0]        wstrb_o,
    output logic [DATA_W-1:0] wdata_o,
    output logic [DATA_W-1:0] load_val_o
);

    logic [DATA_W-1:0] shifted;
    logic [4:0]        sh_amt;

    always_comb begin
        wstrb_o = 4'b1111;
        wdata_o = rs2_i;
        case (op_i[1:0])
            2'b00: begin
                wstrb_o = 4'b0001 << addr_lo_i;
                wdata_o = {(DATA_W/8){rs2_i[7:0]}};
            end
            2'b01: begin
                // Upper strobe bits fall off when the halfword crosses lane 3.
                wstrb_o = 4'b0011 << addr_lo_i;
                wdata_o = {(DATA_W/16){rs2_i[15:0]}};
            end
            default: begin
                wstrb_o = 4'b1111;
                wdata_o = rs2_i;
            end
        endcase
    end

    always_comb begin
        sh_amt  = {addr_lo_i, 3'b000};
        shifted = rdata_i >> sh_amt;
        case (op_i)
            LSU_B:   load_val_o = {{(DATA_W-8){shifted[7]}}, shifted[7:0]};
            LSU_H:   load_val_o = {{(DATA_W-16){shifted[15]}}, shifted[15:0]};
            LSU_BU:  load_val_o = {{(DATA_W-8){1'b0}}, shifted[7:0]};
            LSU_HU:  load_val_o = {{(DATA_W-16){1'b0}}, shifted[15:0]};
            default: load_val_o = rdata_i;
        endcase
    end

endmodule

// File: rtl/lsu_stage.sv
// Memory-access pipeline stage: one instruction in flight, single req/rsp
// per load/store, registered results toward writeback.
// Optional misaligned-access trap under `define LSU_MISALIGN_CHECK_EN.
//
// state | meaning
// IDLE  | ready for a new instruction; non-memory ops complete here
// REQ   | memory request presented, waiting for mem_req_ready
// RSP   | request accepted, waiting for mem_rsp_valid
module lsu_stage
    import lsu_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = DATA_BUS
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              prev_valid,
    output logic              this_ready,
    output logic              next_valid,
    input  logic              next_ready,
    input  logic              ex_mem_ren,
    input  logic              ex_mem_wen,
    input  logic [2:0]        ex_mem_op,
    input  logic [DATA_W-1:0] ex_alu_result,
    input  logic [DATA_W-1:0] ex_store_data,
    input  logic              ex_reg_wen,
    input  logic [1:0]        ex_reg_wdata_sel,
    input  logic [DATA_W-1:0] ex_csr_rdata,
    output logic              wb_reg_wen,
    output logic [1:0]        reg_wdata_sel,
    output logic [DATA_W-1:0] csr_rdata,
    output logic [DATA_W-1:0] alu_result,
    output logic [DATA_W-1:0] dmem_rdata,
    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic              mem_req_we,
    output logic [ADDR_W-1:0] mem_req_addr,
    output logic [DATA_W-1:0] mem_req_wdata,
    output logic [3:0]        mem_req_wstrb,
    input  logic              mem_rsp_valid,
    input  logic [DATA_W-1:0] mem_rsp_rdata,
    output logic              misalign
);

    lsu_state_e state_q, state_d;

    logic [2:0]        op_q;
    logic [DATA_W-1:0] alu_q, rs2_q, csr_q;
    logic              we_q, reg_wen_q;
    logic [1:0]        sel_q;

    logic              next_valid_q, next_valid_d;
    logic              wb_reg_wen_q, wb_reg_wen_d;
    logic [1:0]        sel_out_q, sel_out_d;
    logic [DATA_W-1:0] csr_out_q, csr_out_d;
    logic [DATA_W-1:0] alu_out_q, alu_out_d;
    logic [DATA_W-1:0] dmem_out_q, dmem_out_d;
    logic              misalign_q, misalign_d;

    logic [3:0]        al_wstrb;
    logic [DATA_W-1:0] al_wdata, al_load;

    logic accept, is_mem_in, mis_in, mem_go, fast_done, mem_done;

    assign accept    = prev_valid && this_ready;
    assign is_mem_in = ex_mem_ren || ex_mem_wen;
`ifdef LSU_MISALIGN_CHECK_EN
    assign mis_in    = is_mem_in && is_misaligned(ex_mem_op, ex_alu_result[1:0]);
`else
    assign mis_in    = 1'b0;
`endif
    assign mem_go    = accept && is_mem_in && !mis_in;
    assign fast_done = accept && !mem_go;
    assign mem_done  = (state_q == RSP) && mem_rsp_valid;

    lsu_align #(.DATA_W(DATA_W)) u_align (
        .op_i       (op_q),
        .addr_lo_i  (alu_q[1:0]),
        .rs2_i      (rs2_q),
        .rdata_i    (mem_rsp_rdata),
        .wstrb_o    (al_wstrb),
        .wdata_o    (al_wdata),
        .load_val_o (al_load)
    );

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (mem_go)        state_d = REQ;
            REQ:     if (mem_req_ready) state_d = RSP;
            RSP:     if (mem_rsp_valid) state_d = IDLE;
            default:                    state_d = IDLE;
        endcase
    end

    always_comb begin
        this_ready    = (state_q == IDLE) && (!next_valid_q || next_ready);
        mem_req_valid = (state_q == REQ);
        mem_req_we    = 1'b0;
        mem_req_addr  = '0;
        mem_req_wdata = '0;
        mem_req_wstrb = '0;
        if (state_q == REQ) begin
            mem_req_we    = we_q;
            mem_req_addr  = {alu_q[ADDR_W-1:2], 2'b00};
            mem_req_wdata = al_wdata;
            mem_req_wstrb = al_wstrb;
        end
    end

    // Fields of an accepted memory instruction, held until it retires.
    always_ff @(posedge clk) begin
        if (rst) begin
            op_q      <= '0;
            alu_q     <= '0;
            rs2_q     <= '0;
            csr_q     <= '0;
            we_q      <= 1'b0;
            reg_wen_q <= 1'b0;
            sel_q     <= '0;
        end else if (mem_go) begin
            op_q      <= ex_mem_op;
            alu_q     <= ex_alu_result;
            rs2_q     <= ex_store_data;
            csr_q     <= ex_csr_rdata;
            we_q      <= ex_mem_wen && !ex_mem_ren;
            reg_wen_q <= ex_reg_wen;
            sel_q     <= ex_reg_wdata_sel;
        end
    end

    always_comb begin
        next_valid_d = next_valid_q;
        wb_reg_wen_d = wb_reg_wen_q;
        sel_out_d    = sel_out_q;
        csr_out_d    = csr_out_q;
        alu_out_d    = alu_out_q;
        dmem_out_d   = dmem_out_q;
        misalign_d   = misalign_q;
        if (fast_done) begin
            next_valid_d = 1'b1;
            wb_reg_wen_d = ex_reg_wen && !mis_in;
            sel_out_d    = ex_reg_wdata_sel;
            csr_out_d    = ex_csr_rdata;
            alu_out_d    = ex_alu_result;
            dmem_out_d   = '0;
            misalign_d   = mis_in;
        end else if (mem_done) begin
            next_valid_d = 1'b1;
            wb_reg_wen_d = reg_wen_q;
            sel_out_d    = sel_q;
            csr_out_d    = csr_q;
            alu_out_d    = alu_q;
            dmem_out_d   = we_q ? '0 : al_load;
            misalign_d   = 1'b0;
        end else if (next_ready) begin
            next_valid_d = 1'b0;
            wb_reg_wen_d = 1'b0;
            misalign_d   = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            next_valid_q <= 1'b0;
            wb_reg_wen_q <= 1'b0;
            sel_out_q    <= '0;
            csr_out_q    <= '0;
            alu_out_q    <= '0;
            dmem_out_q   <= '0;
            misalign_q   <= 1'b0;
        end else begin
            next_valid_q <= next_valid_d;
            wb_reg_wen_q <= wb_reg_wen_d;
            sel_out_q    <= sel_out_d;
            csr_out_q    <= csr_out_d;
            alu_out_q    <= alu_out_d;
            dmem_out_q   <= dmem_out_d;
            misalign_q   <= misalign_d;
        end
    end

    assign next_valid    = next_valid_q;
    assign wb_reg_wen    = wb_reg_wen_q;
    assign reg_wdata_sel = sel_out_q;
    assign csr_rdata     = csr_out_q;
    assign alu_result    = alu_out_q;
    assign dmem_rdata    = dmem_out_q;
    assign misalign      = misalign_q;

endmodule
